three_input_gate_sweeper: RTL and testbench

- Upstream driver and result collector for the team's three-input programmable gate (4 function codes: XOR3, NAND3, NOR3, XNOR3).
- On a start request it walks every enabled function code and every a/b/c combination, drives them into the gate, and samples the gate output.
- Assembles a 32-bit captured truth table.
- Used for on-chip self-characterisation of the gate stage and as the stimulus source in integration benches.

---
 rtl/three_input_gate_sweeper_if.sv | 29 ++
 rtl/three_input_gate_sweeper.sv | 155 +++++++++++++++
 tb/tb_three_input_gate_sweeper.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/three_input_gate_sweeper_if.sv
// Bus bundle between the gate sweeper and its environment (gate stage
// plus whoever requests sweeps and reads back the captured table).
// slave  : the sweeper itself
// master : the environment (start requester, gate feedback, table reader)
interface three_input_gate_sweeper_if;
    logic        i_start;
    logic        i_f;
    logic        o_a;
    logic        o_b;
    logic        o_c;
    logic [1:0]  o_code;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_table;
    logic        o_table_valid;
    logic [3:0]  o_mismatch;

    modport slave (
        input  i_start, i_f,
        output o_a, o_b, o_c, o_code, o_busy, o_done,
               o_table, o_table_valid, o_mismatch
    );

    modport master (
        output i_start, i_f,
        input  o_a, o_b, o_c, o_code, o_busy, o_done,
               o_table, o_table_valid, o_mismatch
    );
endinterface

// File: rtl/three_input_gate_sweeper.sv
// Three-input gate sweeper: walks every enabled function code and every
// a/b/c combination, holds each vector SETTLE_CYCLES+1 cycles, samples the
// gate output on the last held cycle and assembles a 32-bit truth table
// (bit index = code*8 + {a,b,c}).
// Optional golden compare: define THREE_INPUT_GATE_SWEEPER_CHECK_EN to build
// the per-code mismatch flags; otherwise o_mismatch is tied to zero.
module three_input_gate_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  CODE_MASK     = 4'b1111
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    three_input_gate_sweeper_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] GOLDEN = 32'h69017F96;
    localparam logic [3:0]  SETTLE = SETTLE_CYCLES[3:0];

    // Returns {found, code}: lowest enabled code that is >= from.
    function automatic logic [2:0] next_enabled(input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if ((k >= int'(from)) && CODE_MASK[k]) begin
                r = {1'b1, k[1:0]};
            end
        end
        return r;
    endfunction

    localparam logic [2:0] FIRST_SEL  = next_enabled(3'd0);
    localparam logic [1:0] FIRST_CODE = FIRST_SEL[1:0];
    localparam logic       MASK_EMPTY = (CODE_MASK == 4'b0000);

    state_t      state_q, state_d;
    logic [1:0]  code_q, code_d;
    logic [2:0]  abc_q, abc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] table_q, table_d;
    logic        valid_q, valid_d;
    logic [2:0]  nxt_sel;
    logic        start_accept;

    assign nxt_sel      = next_enabled({1'b0, code_q} + 3'd1);
    assign start_accept = (state_q == ST_IDLE) && bus.i_start;

    // State and datapath registers; reset aborts any sweep without a done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            code_q  <= 2'd0;
            abc_q   <= 3'd0;
            cnt_q   <= 4'd0;
            table_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            abc_q   <= abc_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: settle counting, sampling, vector and code advance.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        abc_d   = abc_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    table_d = 32'd0;
                    valid_d = 1'b0;
                    cnt_d   = 4'd0;
                    abc_d   = 3'd0;
                    code_d  = FIRST_CODE;
                    state_d = MASK_EMPTY ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q != SETTLE) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    // Last held cycle of this vector: capture the gate output.
                    table_d[{code_q, abc_q}] = bus.i_f;
                    cnt_d = 4'd0;
                    if (abc_q != 3'b111) begin
                        abc_d = abc_q + 3'd1;
                    end else if (nxt_sel[2]) begin
                        code_d = nxt_sel[1:0];
                        abc_d  = 3'd0;
                    end else begin
                        // Final vector stays on the outputs.
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Valid rises as the sweeper returns to IDLE, so a held start
                // sees it for exactly the one IDLE cycle between sweeps.
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_a           = abc_q[2];
    assign bus.o_b           = abc_q[1];
    assign bus.o_c           = abc_q[0];
    assign bus.o_code        = code_q;
    assign bus.o_busy        = (state_q == ST_RUN);
    assign bus.o_done        = (state_q == ST_DONE);
    assign bus.o_table       = table_q;
    assign bus.o_table_valid = valid_q;

`ifdef THREE_INPUT_GATE_SWEEPER_CHECK_EN
    logic [3:0] mism_calc;
    logic [3:0] mismatch_q;
    genvar gi;

    for (gi = 0; gi < 4; gi++) begin : g_cmp
        assign mism_calc[gi] = CODE_MASK[gi] && (table_q[8*gi +: 8] != GOLDEN[8*gi +: 8]);
    end

    // Golden-compare flags: cleared on accepted start, captured in the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mismatch_q <= 4'b0000;
        end else if (start_accept) begin
            mismatch_q <= 4'b0000;
        end else if (state_q == ST_DONE) begin
            mismatch_q <= mism_calc;
        end
    end

    assign bus.o_mismatch = mismatch_q;
`else
    assign bus.o_mismatch = 4'b0000;
`endif

endmodule

// File: tb/tb_three_input_gate_sweeper.sv
// Directed bench for three_input_gate_sweeper. Three instances cover the
// default configuration, a sparse code mask with no settle, and an empty mask.
module tb_three_input_gate_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stuck2 = 1'b0;
    logic [2:0] start_v = 3'b000;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    three_input_gate_sweeper_if if0 ();
    three_input_gate_sweeper_if if1 ();
    three_input_gate_sweeper_if if2 ();

    three_input_gate_sweeper #(.SETTLE_CYCLES(1), .CODE_MASK(4'b1111)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(if0));
    three_input_gate_sweeper #(.SETTLE_CYCLES(0), .CODE_MASK(4'b0101)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(if1));
    three_input_gate_sweeper #(.SETTLE_CYCLES(1), .CODE_MASK(4'b0000)) dut2 (
        .i_clk(clk), .i_rst(rst), .bus(if2));

    // Reference gate: XOR3, NAND3, NOR3, XNOR3; optional stuck-at-1 on code 2.
    function automatic logic gate(input logic [1:0] code, input logic a,
                                  input logic b, input logic c, input logic stk);
        case (code)
            2'd0:    return a ^ b ^ c;
            2'd1:    return ~(a & b & c);
            2'd2:    return stk ? 1'b1 : ~(a | b | c);
            default: return ~(a ^ b ^ c);
        endcase
    endfunction

    assign if0.i_f = gate(if0.o_code, if0.o_a, if0.o_b, if0.o_c, stuck2);
    assign if1.i_f = gate(if1.o_code, if1.o_a, if1.o_b, if1.o_c, 1'b0);
    assign if2.i_f = gate(if2.o_code, if2.o_a, if2.o_b, if2.o_c, 1'b0);
    assign if0.i_start = start_v[0];
    assign if1.i_start = start_v[1];
    assign if2.i_start = start_v[2];

    logic [2:0]  done_v, busy_v, valid_v;
    logic [1:0]  code_v [3];
    logic [31:0] tbl_v  [3];
    assign done_v  = {if2.o_done, if1.o_done, if0.o_done};
    assign busy_v  = {if2.o_busy, if1.o_busy, if0.o_busy};
    assign valid_v = {if2.o_table_valid, if1.o_table_valid, if0.o_table_valid};
    assign code_v[0] = if0.o_code;
    assign code_v[1] = if1.o_code;
    assign code_v[2] = if2.o_code;
    assign tbl_v[0]  = if0.o_table;
    assign tbl_v[1]  = if1.o_table;
    assign tbl_v[2]  = if2.o_table;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on instance d; returns done latency (cycles after the start
    // edge, 0 if it never came), busy cycle count and the set of codes driven.
    task automatic run_sweep(input int d, output int lat, output int busy_n,
                             output logic [3:0] seen);
        int cyc;
        lat = 0;
        busy_n = 0;
        seen = 4'b0000;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        cyc = 1;
        while (!done_v[d] && cyc < 400) begin
            if (busy_v[d]) begin
                busy_n++;
                seen[code_v[d]] = 1'b1;
            end
            tick();
            cyc++;
        end
        if (done_v[d]) lat = cyc;
    endtask

    logic [31:0] exp_mism;
    int lat, busy_n, n, vcnt, dcnt;
    logic [3:0] seen;
    logic [31:0] tbl_restart;

    initial begin
`ifdef THREE_INPUT_GATE_SWEEPER_CHECK_EN
        exp_mism = 32'h4;
`else
        exp_mism = 32'h0;
`endif
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy",  {31'd0, if0.o_busy}, 32'd0);
        check("rst_done",  {31'd0, if0.o_done}, 32'd0);
        check("rst_table", if0.o_table, 32'd0);
        check("rst_valid", {31'd0, if0.o_table_valid}, 32'd0);
        check("rst_vec",   {27'd0, if0.o_code, if0.o_a, if0.o_b, if0.o_c}, 32'd0);
        check("rst_mism",  {28'd0, if0.o_mismatch}, 32'd0);

        // Full default sweep with a correct gate
        run_sweep(0, lat, busy_n, seen);
        check("full_lat",   lat, 32'd65);
        check("full_busy",  busy_n, 32'd64);
        check("full_codes", {28'd0, seen}, 32'hF);
        check("full_table", if0.o_table, 32'h69017F96);
        check("full_vec",   {27'd0, if0.o_code, if0.o_a, if0.o_b, if0.o_c}, 32'h1F);
        tick();
        check("full_valid", {31'd0, if0.o_table_valid}, 32'd1);
        check("full_mism",  {28'd0, if0.o_mismatch}, 32'd0);
        tick();
        check("full_hold",  if0.o_table, 32'h69017F96);

        // Sparse mask, no settle
        run_sweep(1, lat, busy_n, seen);
        check("sparse_lat",   lat, 32'd17);
        check("sparse_busy",  busy_n, 32'd16);
        check("sparse_codes", {28'd0, seen}, 32'h5);
        check("sparse_table", if1.o_table, 32'h00010096);

        // Code 2 stuck at 1
        stuck2 = 1'b1;
        run_sweep(0, lat, busy_n, seen);
        stuck2 = 1'b0;
        check("stuck_lat",   lat, 32'd65);
        check("stuck_byte2", {24'd0, if0.o_table[23:16]}, 32'hFF);
        check("stuck_table", if0.o_table, 32'h69FF7F96);
        tick();
        check("stuck_mism",  {28'd0, if0.o_mismatch}, exp_mism);

        // Reset at cycle 20 of a sweep
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (19) tick();
        check("abort_busy_pre", {31'd0, if0.o_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",  {31'd0, if0.o_busy}, 32'd0);
        check("abort_table", if0.o_table, 32'd0);
        check("abort_valid", {31'd0, if0.o_table_valid}, 32'd0);
        check("abort_vec",   {27'd0, if0.o_code, if0.o_a, if0.o_b, if0.o_c}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (if0.o_done || if0.o_busy) dcnt++;
            tick();
        end
        check("abort_quiet", dcnt, 32'd0);
        run_sweep(0, lat, busy_n, seen);
        check("rerun_lat",   lat, 32'd65);
        check("rerun_table", if0.o_table, 32'h69017F96);

        // Start held high: back-to-back sweeps
        tick();
        start_v[1] = 1'b1;
        tick();
        n = 1;
        while (!if1.o_done && n < 400) begin
            tick();
            n++;
        end
        check("b2b_lat1", n, 32'd17);
        n = 0;
        vcnt = 0;
        tbl_restart = 32'hFFFF_FFFF;
        do begin
            tick();
            n++;
            if (if1.o_table_valid) vcnt++;
            if (n == 2) tbl_restart = if1.o_table;
        end while (!if1.o_done && n < 400);
        start_v[1] = 1'b0;
        check("b2b_period",  n, 32'd18);
        check("b2b_valid1",  vcnt, 32'd1);
        check("b2b_clear",   tbl_restart, 32'd0);
        check("b2b_table2",  if1.o_table, 32'h00010096);
        tick();
        tick();
        check("b2b_idle",    {30'd0, if1.o_busy, if1.o_table_valid}, 32'd1);

        // Empty mask
        run_sweep(2, lat, busy_n, seen);
        check("empty_lat",   lat, 32'd1);
        check("empty_busy",  busy_n, 32'd0);
        check("empty_table", if2.o_table, 32'd0);
        tick();
        check("empty_valid", {31'd0, if2.o_table_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
